// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of an asynchronous
// input in clk cycles and flags a stuck line. Optional deglitch: PWM_CAPTURE_DEGLITCH_EN.
module pwm_capture #(
    parameter int CNT_W    = 32,
    parameter int TIMEOUT  = 24000,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level
);

`ifdef PWM_CAPTURE_DEGLITCH_EN
    localparam int MASK_LEN = 3 + FILT_LEN;
`else
    localparam int MASK_LEN = 3;
`endif
    localparam int MASK_W = $clog2(3 + FILT_LEN + 1);

    localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + ONE;
    endfunction

    logic              pwm_p0;
    logic              pwm_p1;
    logic              lvl_p2;
    logic              lvl_p3;
    logic              lvl_next;
    logic [MASK_W-1:0] mask_p0;
    logic              masked;
    logic              rise;
    logic              fall;
    logic              timeout_hit;

    state_t            state;
    state_t            state_next;
    logic              load_hi;
    logic              publish;
    logic [CNT_W-1:0]  ctr;
    logic [CNT_W-1:0]  hi_lat;

    // Stage p0/p1: two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_p0 <= 1'b0;
            pwm_p1 <= 1'b0;
        end else begin
            pwm_p0 <= pwm_in;
            pwm_p1 <= pwm_p0;
        end
    end

`ifdef PWM_CAPTURE_DEGLITCH_EN
    localparam int FILT_W = $clog2(FILT_LEN) + 1;
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_LEN - 1);

    logic [FILT_W-1:0] filt_cnt_p2;

    // Level follows the synchronised input only after FILT_LEN agreeing samples
    always_comb begin
        lvl_next = lvl_p2;
        if ((pwm_p1 != lvl_p2) && (filt_cnt_p2 == FILT_LAST))
            lvl_next = pwm_p1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            filt_cnt_p2 <= '0;
        else if ((pwm_p1 == lvl_p2) || (filt_cnt_p2 == FILT_LAST))
            filt_cnt_p2 <= '0;
        else
            filt_cnt_p2 <= filt_cnt_p2 + 1'b1;
    end
`else
    assign lvl_next = pwm_p1;
`endif

    // Stage p2/p3: level and its previous value for edge detection.
    // While masked, the previous value tracks the incoming level so a line
    // already high at reset release never looks like a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_p2  <= 1'b0;
            lvl_p3  <= 1'b0;
            mask_p0 <= MASK_W'(MASK_LEN);
        end else begin
            lvl_p2 <= lvl_next;
            lvl_p3 <= masked ? lvl_next : lvl_p2;
            if (masked)
                mask_p0 <= mask_p0 - 1'b1;
        end
    end

    assign masked      = (mask_p0 != '0);
    assign rise        = !masked && lvl_p2 && !lvl_p3;
    assign fall        = !masked && !lvl_p2 && lvl_p3;
    // Fires on the cycle whose update brings ctr to TIMEOUT
    assign timeout_hit = !rise && (ctr == TO_M1);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_hi    = 1'b0;
        publish    = 1'b0;
        case (state)
            IDLE: if (rise) state_next = HIGH;
            HIGH: if (fall) begin
                load_hi    = 1'b1;
                state_next = LOW;
            end
            LOW: if (rise) begin
                publish    = 1'b1;
                state_next = HIGH;
            end
            default: state_next = IDLE;
        endcase
        if (timeout_hit) begin
            state_next = IDLE;
            load_hi    = 1'b0;
            publish    = 1'b0;
        end
    end

    // Latched high time only matters after a HIGH->LOW pass reloads it
    always_ff @(posedge clk) begin
        if (load_hi)
            hi_lat <= ctr;
    end

    // Results stage: one cycle after the rising-edge cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr         <= '0;
            high_cnt    <= '0;
            period_cnt  <= '0;
            meas_valid  <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            ctr        <= rise ? ONE : sat_inc(ctr);
            meas_valid <= publish;
            if (publish) begin
                high_cnt   <= hi_lat;
                period_cnt <= ctr;
            end
            if (rise) begin
                stuck <= 1'b0;
            end else if (timeout_hit) begin
                stuck       <= 1'b1;
                stuck_level <= lvl_p2;
            end
        end
    end

endmodule
